parking_gate_controller: RTL and testbench
==========================================

Name: parking_gate_controller

Overview:
- Sequences the entry and exit gates of an 8-slot car park and owns the slot occupancy vector.
- Arbitrates round-robin between the entry and exit requesters.
- Allocates the lowest free slot on entry and frees the named slot on exit.
- Holds the selected gate open for a fixed time and publishes occupancy, parked count and a full flag to the display logic.

Parameters:
- GATE_CYCLES, 4, number of cycles a gate stays open per served request (legal range 1..15).
- INIT_OCCUPANCY, 8'h00, occupancy vector loaded at reset (bit i = 1 means slot i is occupied).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- entry_req  in  1  level request from the entry sensor, held until entry_ack or reject_full
- exit_req  in  1  level request from the exit sensor, held until exit_ack or exit_error
- exit_slot  in  3  slot being vacated; valid while exit_req is high
- entry_ack  out  1  one-cycle pulse: entry served
- assigned_slot  out  3  slot allocated to the last entry; held until the next entry is served
- exit_ack  out  1  one-cycle pulse: exit served
- reject_full  out  1  one-cycle pulse: entry refused because the park is full
- exit_error  out  1  one-cycle pulse: exit refused because exit_slot is not occupied
- entry_gate_open  out  1  entry barrier drive
- exit_gate_open  out  1  exit barrier drive
- occupancy  out  8  registered occupancy vector
- parked  out  4  population count of occupancy (0..8), combinational from the register
- full  out  1  occupancy == 8'hFF
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, same edge):
  - State = IDLE; occupancy = INIT_OCCUPANCY; assigned_slot = 0; last_served = EXIT, so entry wins the first tie.
  - All pulses and gate outputs are 0.
  - Reset asserted mid-service aborts it: gates drop on the cycle after the reset edge, and no ack is issued.
- FSM states: IDLE, ENTRY_GATE, EXIT_GATE, REJECT.
- IDLE, selection on each edge:
  - Only entry_req high: select entry.
  - Only exit_req high: select exit.
  - Both high: select the opposite of last_served.
  - last_served updates on every selection, including selections that end in reject or error.
- Entry selected:
  - If full: go to REJECT; reject_full = 1 for one cycle; occupancy unchanged.
  - Else: slot = lowest index i with occupancy[i] = 0. On the same edge: set occupancy[slot], load assigned_slot, go to ENTRY_GATE.
- Exit selected:
  - If occupancy[exit_slot] = 0: go to REJECT; exit_error = 1 for one cycle.
  - Else: clear occupancy[exit_slot] on the same edge and go to EXIT_GATE.
- ENTRY_GATE / EXIT_GATE:
  - The matching gate_open is high for exactly GATE_CYCLES consecutive cycles, timed by a 4-bit down-counter.
  - The matching ack is high only in the first of those cycles.
  - After the last gate cycle the FSM returns to IDLE. The gates are never open simultaneously.
- REJECT lasts one cycle, then the FSM returns to IDLE.
- Latency: request sampled at edge N; ack/reject/error, updated occupancy and parked are all visible in cycle N+1.
- Requester rule: a requester drops its req at the edge ending the cycle in which it saw its ack or reject. A req still high in IDLE is a new request.
- Requests arriving while busy are not lost; they are held by the requester and sampled at the next IDLE.
- parked and full track occupancy in the same cycle; there is no extra register stage.
- Boundaries:
  - Entry at 7 occupied fills the last free slot; full rises in the ack cycle.
  - Exit from full clears full in the ack cycle.
  - Back-to-back requests are served with minimum spacing of GATE_CYCLES+1 cycles between acks.

Test Plan:
- Reset with INIT_OCCUPANCY=0, then one entry_req -> entry_ack one cycle later, assigned_slot=0, occupancy=8'h01, parked=1, entry_gate_open high for 4 cycles, busy low on cycle 5.
- occupancy=8'b0000_0111, entry -> assigned_slot=3, occupancy=8'h0F, parked=4. Then exit_slot=1 -> exit_ack, occupancy=8'h0D, parked=3, exit_gate_open high for 4 cycles.
- entry_req and exit_req (exit_slot=0, occupied) held together from reset -> entry served first; exit served next with its ack exactly GATE_CYCLES+1 cycles after entry_ack. Both reqs high again -> entry served (alternation holds).
- Fill to 8'hFF (full=1, parked=8), then entry_req -> reject_full pulse, no gate opens, occupancy unchanged; exit_slot=5 -> occupancy=8'hDF, full=0.
- exit_slot=6 with occupancy[6]=0 -> exit_error pulse only, exit_gate_open stays low, occupancy unchanged.
- Assert reset in gate cycle 2 of an entry -> gate low on the next cycle, occupancy=INIT_OCCUPANCY, state IDLE, no further ack.

Source files
------------

// File: rtl/parking_gate_controller.sv
// ---------------------------------------------------------------------------
// parking_gate_controller
//
// Sequences the entry and exit barriers of an 8-slot car park and owns the
// slot occupancy vector. Entry and exit requesters are arbitrated
// round-robin. An entry gets the lowest free slot, and an exit frees the
// named slot. The selected gate is then held open for GATE_CYCLES cycles.
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   entry_req        level request from the entry sensor
//   exit_req         level request from the exit sensor
//   exit_slot[2:0]   slot being vacated, valid while exit_req is high
//   entry_ack        one-cycle pulse: entry served
//   assigned_slot    slot given to the last served entry (held)
//   exit_ack         one-cycle pulse: exit served
//   reject_full      one-cycle pulse: entry refused, park full
//   exit_error       one-cycle pulse: exit refused, slot not occupied
//   entry_gate_open  entry barrier drive
//   exit_gate_open   exit barrier drive
//   occupancy[7:0]   registered occupancy vector (bit i = slot i taken)
//   parked[3:0]      population count of occupancy
//   full             all eight slots occupied
//   busy             controller is not idle
//   dbg_state[1:0]   raw FSM state for debug/observation
//
// Handshake: each req is a level held by its requester until the matching
// ack/reject/error pulse has been seen. The controller samples reqs only in
// IDLE, so a req raised while busy waits for the next idle edge. The
// controller applies no backpressure beyond that.
// ---------------------------------------------------------------------------
module parking_gate_controller #(
   parameter int unsigned GATE_CYCLES    = 4,
   parameter logic [7:0]  INIT_OCCUPANCY = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_req,
   input  logic       exit_req,
   input  logic [2:0] exit_slot,
   output logic       entry_ack,
   output logic [2:0] assigned_slot,
   output logic       exit_ack,
   output logic       reject_full,
   output logic       exit_error,
   output logic       entry_gate_open,
   output logic       exit_gate_open,
   output logic [7:0] occupancy,
   output logic [3:0] parked,
   output logic       full,
   output logic       busy,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_GATE = 2'd1,
      EXIT_GATE  = 2'd2,
      REJECT     = 2'd3
   } state_t;

   localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] occ, occ_nxt;
   logic [2:0] slot_q, slot_nxt;
   // 1 when the most recent selection was the exit side. In REJECT this bit
   // also tells which requester was refused.
   logic       last_exit, last_exit_nxt;
   logic [2:0] free_slot;
   logic       sel_entry;

   // Lowest free slot: scanning from the top lets the lowest index win.
   always_comb begin
      free_slot = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!occ[i]) free_slot = 3'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         occ       <= INIT_OCCUPANCY;
         slot_q    <= 3'd0;
         last_exit <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         occ       <= occ_nxt;
         slot_q    <= slot_nxt;
         last_exit <= last_exit_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      occ_nxt         = occ;
      slot_nxt        = slot_q;
      last_exit_nxt   = last_exit;
      sel_entry       = 1'b0;
      entry_ack       = 1'b0;
      exit_ack        = 1'b0;
      reject_full     = 1'b0;
      exit_error      = 1'b0;
      entry_gate_open = 1'b0;
      exit_gate_open  = 1'b0;

      case (state)
         IDLE: begin
            if (entry_req || exit_req) begin
               // On a tie, serve the side that was not served last.
               sel_entry     = entry_req && (!exit_req || last_exit);
               last_exit_nxt = !sel_entry;
               if (sel_entry) begin
                  if (&occ) begin
                     state_nxt = REJECT;
                  end else begin
                     occ_nxt[free_slot] = 1'b1;
                     slot_nxt           = free_slot;
                     cnt_nxt            = GATE_LOAD;
                     state_nxt          = ENTRY_GATE;
                  end
               end else begin
                  if (!occ[exit_slot]) begin
                     state_nxt = REJECT;
                  end else begin
                     occ_nxt[exit_slot] = 1'b0;
                     cnt_nxt            = GATE_LOAD;
                     state_nxt          = EXIT_GATE;
                  end
               end
            end
         end
         ENTRY_GATE: begin
            entry_gate_open = 1'b1;
            entry_ack       = (cnt == GATE_LOAD);
            cnt_nxt         = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = IDLE;
         end
         EXIT_GATE: begin
            exit_gate_open = 1'b1;
            exit_ack       = (cnt == GATE_LOAD);
            cnt_nxt        = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = IDLE;
         end
         REJECT: begin
            reject_full = !last_exit;
            exit_error  = last_exit;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // parked and full are derived straight from the register, no extra stage.
   always_comb begin
      parked = 4'd0;
      for (int i = 0; i < 8; i++) begin
         parked = parked + {3'd0, occ[i]};
      end
   end

   assign full          = &occ;
   assign occupancy     = occ;
   assign assigned_slot = slot_q;
   assign busy          = (state != IDLE);
   assign dbg_state     = state;

endmodule

// File: tb/tb_parking_gate_controller.sv
// ---------------------------------------------------------------------------
// tb_parking_gate_controller
//
// Random entry/exit traffic against a transaction-level reference model of
// the car park. The model keeps its own occupancy vector and a busy-cycle
// budget. Each clock edge it pushes the expected per-cycle status, and on
// every selection it pushes the expected transaction outcome. A monitor on
// the falling edge pops both queues and compares them with the DUT.
// ---------------------------------------------------------------------------
module tb_parking_gate_controller;

   localparam int unsigned GATE_CYCLES    = 4;
   localparam logic [7:0]  INIT_OCCUPANCY = 8'h00;
   localparam int          N_CYC          = 1500;

   logic       clk = 1'b0;
   logic       reset;
   logic       entry_req;
   logic       exit_req;
   logic [2:0] exit_slot;
   logic       entry_ack;
   logic [2:0] assigned_slot;
   logic       exit_ack;
   logic       reject_full;
   logic       exit_error;
   logic       entry_gate_open;
   logic       exit_gate_open;
   logic [7:0] occupancy;
   logic [3:0] parked;
   logic       full;
   logic       busy;
   logic [1:0] dbg_state;

   parking_gate_controller #(
      .GATE_CYCLES   (GATE_CYCLES),
      .INIT_OCCUPANCY(INIT_OCCUPANCY)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .entry_req      (entry_req),
      .exit_req       (exit_req),
      .exit_slot      (exit_slot),
      .entry_ack      (entry_ack),
      .assigned_slot  (assigned_slot),
      .exit_ack       (exit_ack),
      .reject_full    (reject_full),
      .exit_error     (exit_error),
      .entry_gate_open(entry_gate_open),
      .exit_gate_open (exit_gate_open),
      .occupancy      (occupancy),
      .parked         (parked),
      .full           (full),
      .busy           (busy),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;

   // Per-cycle status {entry_ack, exit_ack, reject_full, exit_error,
   //                   entry_gate, exit_gate, busy, occ, parked, full, assigned}
   logic [22:0] exp_cyc_q[$];
   // Transaction outcome {kind, assigned, occ, parked, full};
   // kind 0 entry_ack, 1 exit_ack, 2 reject_full, 3 exit_error.
   logic [17:0] exp_txn_q[$];

   logic entry_done = 1'b0;
   logic exit_done  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_occ;
   logic [2:0] m_assigned;
   bit         m_last_exit;
   int         m_hold;   // busy cycles still ahead
   int         m_gate;   // 0 none, 1 entry gate, 2 exit gate

   initial begin
      logic [3:0] pulses;
      logic [1:0] kind;
      bit         sel;
      int         side;  // 0 none, 1 entry, 2 exit
      forever begin
         @(posedge clk);
         pulses = 4'b0000;
         sel    = 1'b0;
         kind   = 2'd0;
         if (reset) begin
            m_occ       = INIT_OCCUPANCY;
            m_assigned  = 3'd0;
            m_last_exit = 1'b1;
            m_hold      = 0;
            m_gate      = 0;
         end else if (m_hold > 0) begin
            m_hold--;
         end else begin
            side = 0;
            if (entry_req && exit_req) side = m_last_exit ? 1 : 2;
            else if (entry_req)        side = 1;
            else if (exit_req)         side = 2;
            if (side == 1) begin
               sel         = 1'b1;
               m_last_exit = 1'b0;
               if (m_occ == 8'hFF) begin
                  kind = 2'd2; m_hold = 1; m_gate = 0;
               end else begin
                  for (int i = 0; i < 8; i++) begin
                     if (!m_occ[i]) begin
                        m_occ[i]   = 1'b1;
                        m_assigned = 3'(i);
                        break;
                     end
                  end
                  kind = 2'd0; m_hold = GATE_CYCLES; m_gate = 1;
               end
            end else if (side == 2) begin
               sel         = 1'b1;
               m_last_exit = 1'b1;
               if (!m_occ[exit_slot]) begin
                  kind = 2'd3; m_hold = 1; m_gate = 0;
               end else begin
                  m_occ[exit_slot] = 1'b0;
                  kind = 2'd1; m_hold = GATE_CYCLES; m_gate = 2;
               end
            end
         end
         if (sel) begin
            pulses = 4'b1000 >> kind;
            exp_txn_q.push_back({kind, m_assigned, m_occ, 4'($countones(m_occ)),
                                 (m_occ == 8'hFF)});
         end
         exp_cyc_q.push_back({pulses,
                              (m_hold > 0 && m_gate == 1),
                              (m_hold > 0 && m_gate == 2),
                              (m_hold > 0),
                              m_occ, 4'($countones(m_occ)), (m_occ == 8'hFF),
                              m_assigned});
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic [22:0] e_cyc;
      logic [17:0] e_txn;
      logic [1:0]  k;
      forever begin
         @(negedge clk);
         if (exp_cyc_q.size() > 0) begin
            e_cyc = exp_cyc_q.pop_front();
            chk("cycle_status",
                {9'd0, entry_ack, exit_ack, reject_full, exit_error, entry_gate_open,
                 exit_gate_open, busy, occupancy, parked, full, assigned_slot},
                {9'd0, e_cyc});
         end
         if (entry_gate_open && exit_gate_open) chk("gates_exclusive", 32'd1, 32'd0);
         if (entry_ack || exit_ack || reject_full || exit_error) begin
            if (entry_ack || reject_full) entry_done = 1'b1;
            if (exit_ack || exit_error)   exit_done  = 1'b1;
            k = entry_ack ? 2'd0 : exit_ack ? 2'd1 : reject_full ? 2'd2 : 2'd3;
            if (exp_txn_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL txn_unexpected: got kind %0d expected none at %0t", k, $time);
            end else begin
               e_txn = exp_txn_q.pop_front();
               chk("txn", {14'd0, k, assigned_slot, occupancy, parked, full},
                   {14'd0, e_txn});
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic pick_exit_slot();
      logic [2:0] s;
      s = 3'($urandom_range(0, 7));
      if (m_occ != 8'h00 && $urandom_range(0, 3) != 0) begin
         for (int t = 0; t < 16 && !m_occ[s]; t++) s = 3'($urandom_range(0, 7));
      end
      exit_slot = s;
   endtask

   initial begin
      int ent_pct;
      int ex_pct;
      bit allow;
      reset     = 1'b1;
      entry_req = 1'b0;
      exit_req  = 1'b0;
      exit_slot = 3'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int c = 0; c < N_CYC; c++) begin
         @(posedge clk);
         #1;
         if (c < 500)       begin ent_pct = 70; ex_pct = 25; end
         else if (c < 1000) begin ent_pct = 50; ex_pct = 50; end
         else               begin ent_pct = 25; ex_pct = 60; end
         allow = (c < N_CYC - 40);
         reset = allow && ($urandom_range(0, 199) == 0);
         if (entry_req && entry_done) entry_req = 1'b0;
         else if (!entry_req && allow && $urandom_range(0, 99) < ent_pct) entry_req = 1'b1;
         entry_done = 1'b0;
         if (exit_req && exit_done) exit_req = 1'b0;
         else if (!exit_req && allow && $urandom_range(0, 99) < ex_pct) begin
            pick_exit_slot();
            exit_req = 1'b1;
         end
         exit_done = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("txn_drain", 32'(exp_txn_q.size()), 32'd0);
      chk("reqs_served", {30'd0, entry_req, exit_req}, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
